// File: rtl/msrv32_stage2_pipe_reg_pkg.sv
// Shared MSRV32 width constants used by the stage-2 pipeline register slice.
package msrv32_pkg;

  localparam int XLEN        = 32;
  localparam int REG_ADDR_W  = 5;
  localparam int CSR_ADDR_W  = 12;
  localparam int ALU_OP_W    = 4;
  localparam int LOAD_SIZE_W = 2;
  localparam int WB_SEL_W    = 3;
  localparam int CSR_OP_W    = 3;

endpackage

// File: rtl/msrv32_stage2_pipe_reg_if.sv
// Bundle of stage-1 results entering the stage-2 register and the registered copies leaving it.
interface msrv32_stage2_pipe_reg_if;
  import msrv32_pkg::*;

  // stage-1 results
  logic [REG_ADDR_W-1:0]  rd_addr_in;
  logic [CSR_ADDR_W-1:0]  csr_addr_in;
  logic [XLEN-1:0]        rs1_in;
  logic [XLEN-1:0]        rs2_in;
  logic [XLEN-1:0]        pc_in;
  logic [XLEN-1:0]        pc_plus_4_in;
  logic [ALU_OP_W-1:0]    alu_opcode_in;
  logic [LOAD_SIZE_W-1:0] load_size_in;
  logic                   load_unsigned_in;
  logic                   alu_src_in;
  logic                   csr_wr_en_in;
  logic                   rf_wr_en_in;
  logic [WB_SEL_W-1:0]    wb_mux_sel_in;
  logic [CSR_OP_W-1:0]    csr_op_in;
  logic [XLEN-1:0]        imm_in;
  logic [XLEN-1:0]        iadder_out_in;
  logic                   branch_taken_in;

  // registered copies presented to execute/writeback
  logic [REG_ADDR_W-1:0]  rd_addr_reg_out;
  logic [CSR_ADDR_W-1:0]  csr_addr_reg_out;
  logic [XLEN-1:0]        rs1_reg_out;
  logic [XLEN-1:0]        rs2_reg_out;
  logic [XLEN-1:0]        pc_reg_out;
  logic [XLEN-1:0]        pc_plus_4_reg_out;
  logic [ALU_OP_W-1:0]    alu_opcode_reg_out;
  logic [LOAD_SIZE_W-1:0] load_size_reg_out;
  logic                   load_unsigned_reg_out;
  logic                   alu_src_reg_out;
  logic                   csr_wr_en_reg_out;
  logic                   rf_wr_en_reg_out;
  logic [WB_SEL_W-1:0]    wb_mux_sel_reg_out;
  logic [CSR_OP_W-1:0]    csr_op_reg_out;
  logic [XLEN-1:0]        imm_reg_out;
  logic [XLEN-1:0]        iadder_out_reg_out;

  // stage 1 side: produces the results, observes the registered copies
  modport master (
    output rd_addr_in, csr_addr_in, rs1_in, rs2_in, pc_in, pc_plus_4_in,
           alu_opcode_in, load_size_in, load_unsigned_in, alu_src_in,
           csr_wr_en_in, rf_wr_en_in, wb_mux_sel_in, csr_op_in,
           imm_in, iadder_out_in, branch_taken_in,
    input  rd_addr_reg_out, csr_addr_reg_out, rs1_reg_out, rs2_reg_out,
           pc_reg_out, pc_plus_4_reg_out, alu_opcode_reg_out, load_size_reg_out,
           load_unsigned_reg_out, alu_src_reg_out, csr_wr_en_reg_out,
           rf_wr_en_reg_out, wb_mux_sel_reg_out, csr_op_reg_out,
           imm_reg_out, iadder_out_reg_out
  );

  // pipeline register side
  modport slave (
    input  rd_addr_in, csr_addr_in, rs1_in, rs2_in, pc_in, pc_plus_4_in,
           alu_opcode_in, load_size_in, load_unsigned_in, alu_src_in,
           csr_wr_en_in, rf_wr_en_in, wb_mux_sel_in, csr_op_in,
           imm_in, iadder_out_in, branch_taken_in,
    output rd_addr_reg_out, csr_addr_reg_out, rs1_reg_out, rs2_reg_out,
           pc_reg_out, pc_plus_4_reg_out, alu_opcode_reg_out, load_size_reg_out,
           load_unsigned_reg_out, alu_src_reg_out, csr_wr_en_reg_out,
           rf_wr_en_reg_out, wb_mux_sel_reg_out, csr_op_reg_out,
           imm_reg_out, iadder_out_reg_out
  );

endinterface

// File: rtl/msrv32_stage2_pipe_reg_dff.sv
// Width-parameterised pipeline flop, asynchronously cleared to zero.
module msrv32_pipe_dff #(
  parameter int W = 1
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic [W-1:0] d_in,
  output logic [W-1:0] q_out
);

  logic [W-1:0] r_q;

  // capture every cycle; reset wins immediately and holds the field at zero
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) r_q <= '0;
    else        r_q <= d_in;
  end

  assign q_out = r_q;

endmodule

// File: rtl/msrv32_stage2_pipe_reg.sv
// Stage-2 pipeline register of the MSRV32 core: one flop bank per stage-1 field, no enable.
module msrv32_stage2_pipe_reg
  import msrv32_pkg::*;
(
  input  logic                    clk_in,
  input  logic                    rst_in,
  msrv32_stage2_pipe_reg_if.slave bus
);

  // Branch flushing happens in stage 1, so the taken flag is deliberately not used here.
  logic w_unused_branch_taken;
  assign w_unused_branch_taken = bus.branch_taken_in;

  logic [REG_ADDR_W-1:0]  w_rd_addr;
  logic [CSR_ADDR_W-1:0]  w_csr_addr;
  logic [XLEN-1:0]        w_rs1, w_rs2, w_pc, w_pc_plus_4, w_imm, w_iadder_out;
  logic [ALU_OP_W-1:0]    w_alu_opcode;
  logic [LOAD_SIZE_W-1:0] w_load_size;
  logic                   w_load_unsigned, w_alu_src, w_csr_wr_en, w_rf_wr_en;
  logic [WB_SEL_W-1:0]    w_wb_mux_sel;
  logic [CSR_OP_W-1:0]    w_csr_op;

  msrv32_pipe_dff #(.W(REG_ADDR_W))  u_rd_addr       (.clk_in(clk_in), .rst_in(rst_in), .d_in(bus.rd_addr_in),       .q_out(w_rd_addr));
  msrv32_pipe_dff #(.W(CSR_ADDR_W))  u_csr_addr      (.clk_in(clk_in), .rst_in(rst_in), .d_in(bus.csr_addr_in),      .q_out(w_csr_addr));
  msrv32_pipe_dff #(.W(XLEN))        u_rs1           (.clk_in(clk_in), .rst_in(rst_in), .d_in(bus.rs1_in),           .q_out(w_rs1));
  msrv32_pipe_dff #(.W(XLEN))        u_rs2           (.clk_in(clk_in), .rst_in(rst_in), .d_in(bus.rs2_in),           .q_out(w_rs2));
  msrv32_pipe_dff #(.W(XLEN))        u_pc            (.clk_in(clk_in), .rst_in(rst_in), .d_in(bus.pc_in),            .q_out(w_pc));
  msrv32_pipe_dff #(.W(XLEN))        u_pc_plus_4     (.clk_in(clk_in), .rst_in(rst_in), .d_in(bus.pc_plus_4_in),     .q_out(w_pc_plus_4));
  msrv32_pipe_dff #(.W(ALU_OP_W))    u_alu_opcode    (.clk_in(clk_in), .rst_in(rst_in), .d_in(bus.alu_opcode_in),    .q_out(w_alu_opcode));
  msrv32_pipe_dff #(.W(LOAD_SIZE_W)) u_load_size     (.clk_in(clk_in), .rst_in(rst_in), .d_in(bus.load_size_in),     .q_out(w_load_size));
  msrv32_pipe_dff #(.W(1))           u_load_unsigned (.clk_in(clk_in), .rst_in(rst_in), .d_in(bus.load_unsigned_in), .q_out(w_load_unsigned));
  msrv32_pipe_dff #(.W(1))           u_alu_src       (.clk_in(clk_in), .rst_in(rst_in), .d_in(bus.alu_src_in),       .q_out(w_alu_src));
  msrv32_pipe_dff #(.W(1))           u_csr_wr_en     (.clk_in(clk_in), .rst_in(rst_in), .d_in(bus.csr_wr_en_in),     .q_out(w_csr_wr_en));
  msrv32_pipe_dff #(.W(1))           u_rf_wr_en      (.clk_in(clk_in), .rst_in(rst_in), .d_in(bus.rf_wr_en_in),      .q_out(w_rf_wr_en));
  msrv32_pipe_dff #(.W(WB_SEL_W))    u_wb_mux_sel    (.clk_in(clk_in), .rst_in(rst_in), .d_in(bus.wb_mux_sel_in),    .q_out(w_wb_mux_sel));
  msrv32_pipe_dff #(.W(CSR_OP_W))    u_csr_op        (.clk_in(clk_in), .rst_in(rst_in), .d_in(bus.csr_op_in),        .q_out(w_csr_op));
  msrv32_pipe_dff #(.W(XLEN))        u_imm           (.clk_in(clk_in), .rst_in(rst_in), .d_in(bus.imm_in),           .q_out(w_imm));
  msrv32_pipe_dff #(.W(XLEN))        u_iadder_out    (.clk_in(clk_in), .rst_in(rst_in), .d_in(bus.iadder_out_in),    .q_out(w_iadder_out));

  assign bus.rd_addr_reg_out       = w_rd_addr;
  assign bus.csr_addr_reg_out      = w_csr_addr;
  assign bus.rs1_reg_out           = w_rs1;
  assign bus.rs2_reg_out           = w_rs2;
  assign bus.pc_reg_out            = w_pc;
  assign bus.pc_plus_4_reg_out     = w_pc_plus_4;
  assign bus.alu_opcode_reg_out    = w_alu_opcode;
  assign bus.load_size_reg_out     = w_load_size;
  assign bus.load_unsigned_reg_out = w_load_unsigned;
  assign bus.alu_src_reg_out       = w_alu_src;
  assign bus.csr_wr_en_reg_out     = w_csr_wr_en;
  assign bus.rf_wr_en_reg_out      = w_rf_wr_en;
  assign bus.wb_mux_sel_reg_out    = w_wb_mux_sel;
  assign bus.csr_op_reg_out        = w_csr_op;
  assign bus.imm_reg_out           = w_imm;
  assign bus.iadder_out_reg_out    = w_iadder_out;

endmodule

// File: tb/tb_msrv32_stage2_pipe_reg.sv
// Scoreboard bench for the stage-2 pipeline register: stimulus pushes expected captures, a monitor pops them after each edge.
module tb_msrv32_stage2_pipe_reg;
  import msrv32_pkg::*;

  typedef struct packed {
    logic [4:0]  rd;
    logic [11:0] csr;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [3:0]  aluop;
    logic [1:0]  lsz;
    logic        lu;
    logic        asrc;
    logic        csrwe;
    logic        rfwe;
    logic [2:0]  wb;
    logic [2:0]  csrop;
    logic [31:0] imm;
    logic [31:0] iadd;
  } s2_t;

  logic clk_in = 1'b0;
  logic rst_in = 1'b1;

  msrv32_stage2_pipe_reg_if bus();

  msrv32_stage2_pipe_reg dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;

  int   checks = 0;
  int   errors = 0;
  int   cap_idx = 0;
  s2_t  exp_q[$];
  s2_t  last_exp = '0;

  function automatic s2_t actual();
    s2_t a;
    a.rd    = bus.rd_addr_reg_out;
    a.csr   = bus.csr_addr_reg_out;
    a.rs1   = bus.rs1_reg_out;
    a.rs2   = bus.rs2_reg_out;
    a.pc    = bus.pc_reg_out;
    a.pc4   = bus.pc_plus_4_reg_out;
    a.aluop = bus.alu_opcode_reg_out;
    a.lsz   = bus.load_size_reg_out;
    a.lu    = bus.load_unsigned_reg_out;
    a.asrc  = bus.alu_src_reg_out;
    a.csrwe = bus.csr_wr_en_reg_out;
    a.rfwe  = bus.rf_wr_en_reg_out;
    a.wb    = bus.wb_mux_sel_reg_out;
    a.csrop = bus.csr_op_reg_out;
    a.imm   = bus.imm_reg_out;
    a.iadd  = bus.iadder_out_reg_out;
    return a;
  endfunction

  task automatic check(input string name, input s2_t exp);
    s2_t a;
    a = actual();
    checks++;
    if (a !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, a, exp);
    end else begin
      $display("ok   %s %h", name, a);
    end
  endtask

  task automatic apply(input s2_t v, input logic br);
    bus.rd_addr_in       = v.rd;
    bus.csr_addr_in      = v.csr;
    bus.rs1_in           = v.rs1;
    bus.rs2_in           = v.rs2;
    bus.pc_in            = v.pc;
    bus.pc_plus_4_in     = v.pc4;
    bus.alu_opcode_in    = v.aluop;
    bus.load_size_in     = v.lsz;
    bus.load_unsigned_in = v.lu;
    bus.alu_src_in       = v.asrc;
    bus.csr_wr_en_in     = v.csrwe;
    bus.rf_wr_en_in      = v.rfwe;
    bus.wb_mux_sel_in    = v.wb;
    bus.csr_op_in        = v.csrop;
    bus.imm_in           = v.imm;
    bus.iadder_out_in    = v.iadd;
    bus.branch_taken_in  = br;
  endtask

  // One cycle of stimulus, issued on the falling edge: set reset and inputs, queue
  // what the next rising edge must produce, then confirm nothing moved before that edge.
  task automatic drive(input string name, input s2_t v, input logic br, input logic rst);
    s2_t e;
    @(negedge clk_in);
    rst_in = rst;
    apply(v, br);
    e = rst ? s2_t'('0) : v;
    exp_q.push_back(e);
    #2;
    if (rst) check({name, "_rst_now"}, '0);
    else     check({name, "_hold"}, last_exp);
    last_exp = e;
  endtask

  function automatic s2_t rand_vec();
    s2_t v;
    v.rd    = 5'($urandom);
    v.csr   = 12'($urandom);
    v.rs1   = $urandom;
    v.rs2   = $urandom;
    v.pc    = $urandom;
    v.pc4   = $urandom;
    v.aluop = 4'($urandom);
    v.lsz   = 2'($urandom);
    v.lu    = 1'($urandom);
    v.asrc  = 1'($urandom);
    v.csrwe = 1'($urandom);
    v.rfwe  = 1'($urandom);
    v.wb    = 3'($urandom);
    v.csrop = 3'($urandom);
    v.imm   = $urandom;
    v.iadd  = $urandom;
    return v;
  endfunction

  // Monitor: just after every rising edge, compare against the oldest queued expectation.
  initial begin : monitor
    s2_t e;
    forever begin
      @(posedge clk_in);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check($sformatf("cap%0d", cap_idx), e);
        cap_idx++;
      end
    end
  end

  initial begin : stim
    s2_t v0, v1, vs;
    apply('0, 1'b0);

    // reset held from time 0: outputs zero before any edge
    #2;
    check("reset_initial", '0);

    // base vector, released from reset on the falling edge at 10ns
    v0 = '{rd: 5'b00100, csr: 12'hCC6, rs1: 32'h55555555, rs2: 32'hAAAAAAAA,
           pc: 32'h33333333, pc4: 32'h55555555, aluop: 4'b1010, lsz: 2'b11,
           lu: 1'b1, asrc: 1'b1, csrwe: 1'b0, rfwe: 1'b1, wb: 3'b001,
           csrop: 3'b010, imm: 32'hF0F0F0F0, iadd: 32'hCCCCCCCC};
    drive("first", v0, 1'b0, 1'b0);

    // only rs1 changes mid-cycle: the old value holds until the edge
    v1 = v0;
    v1.rs1 = 32'h12345678;
    drive("latency", v1, 1'b0, 1'b0);

    // taken branch must not disturb any field, write enables included
    v1.csrwe = 1'b1;
    v1.rfwe  = 1'b1;
    v1.pc    = 32'h00000ABC;
    drive("branch", v1, 1'b1, 1'b0);

    // back-to-back random stream
    for (int i = 0; i < 8; i++) begin
      drive($sformatf("stream%0d", i), rand_vec(), 1'($urandom), 1'b0);
    end

    // reset for three cycles mid-stream, then the next vector is captured
    for (int i = 0; i < 3; i++) begin
      drive($sformatf("midrst%0d", i), rand_vec(), 1'b0, 1'b1);
    end
    drive("post_rst", rand_vec(), 1'b0, 1'b0);
    vs = rand_vec();
    vs.rfwe = 1'b1;
    drive("preload", vs, 1'b0, 1'b0);

    // asynchronous clear between edges while holding non-zero data
    @(negedge clk_in);
    #2;
    rst_in = 1'b1;
    #1;
    check("rst_async", '0);
    last_exp = '0;
    drive("rst_held", vs, 1'b0, 1'b1);

    // let the scoreboard drain, bounded
    repeat (3) @(posedge clk_in);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending want 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
